// File: rtl/video_timing_pkg.sv
// Shared timing constants, sync payload type and configuration helpers for video_timing_pipe.
package video_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam int unsigned FRAME_W      = 8;
    localparam int unsigned MAX_PIPE_LAT = 15;

    // Logical (polarity-free) sync/blank flags carried down the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } sync_t;

    localparam sync_t SYNC_RST = '{hs: 1'b0, vs: 1'b0, blank: 1'b1};

    function automatic int unsigned timing_total(input int unsigned act, input int unsigned fp,
                                                 input int unsigned sw, input int unsigned bp);
        return act + fp + sw + bp;
    endfunction

    // Counters must reach TOTAL-1, the divider needs at least one clock per tick.
    function automatic bit timing_cfg_ok(input int unsigned cw, input int unsigned h_total,
                                         input int unsigned v_total, input int unsigned clk_div,
                                         input int unsigned pipe_lat);
        return (cw >= 1) && (cw < 32) && (clk_div >= 1) && (pipe_lat <= MAX_PIPE_LAT)
            && (h_total <= (32'd1 << cw)) && (v_total <= (32'd1 << cw));
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Shift register of DEPTH stages, advancing only when i_shift is high; depth 0 is a wire.
module sync_delay_line #(
    parameter int unsigned   W       = 1,
    parameter int unsigned   DEPTH   = 0,
    parameter logic [W-1:0]  RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_shift,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = ^{clk, reset, i_shift};
        assign o_q      = i_d;
    end else begin : g_shift
        logic [W-1:0] r_stage [DEPTH];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    r_stage[i] <= RST_VAL;
                end
            end else if (i_shift) begin
                r_stage[0] <= i_d;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign o_q = r_stage[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_pipe.sv
// Parametrised raster timing generator with a latency-matched sync/blank delay
// and a blank-gated registered RGB/sync output stage.
module video_timing_pipe
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned CLK_DIV  = 1,
    parameter int unsigned PIPE_LAT = 0,
    parameter int unsigned RGB_W    = 6,
    parameter int unsigned CW       = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               pix_ce,
    output logic [CW-1:0]      x,
    output logic [CW-1:0]      y,
    output logic               active,
    output logic               sol,
    output logic               sof,
    output logic [FRAME_W-1:0] frame_cnt,
    input  logic [RGB_W-1:0]   rgb_in,
    output logic [RGB_W-1:0]   rgb_out,
    output logic               blank_out,
    output logic               hsync,
    output logic               vsync
);

    localparam int unsigned H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HS_LO   = H_ACTIVE + H_FP;
    localparam int unsigned HS_HI   = H_ACTIVE + H_FP + H_SYNC - 1;
    localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
    localparam int unsigned VS_HI   = V_ACTIVE + V_FP + V_SYNC - 1;

    if (!timing_cfg_ok(CW, H_TOTAL, V_TOTAL, CLK_DIV, PIPE_LAT)) begin : g_cfg_err
        $error("video_timing_pipe: CW too narrow, CLK_DIV < 1 or PIPE_LAT > 15");
    end

    logic [DIV_W-1:0]   r_div;
    logic [CW-1:0]      r_x;
    logic [CW-1:0]      r_y;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic               r_hsync;
    logic               r_vsync;
    logic               r_blank;
    logic [RGB_W-1:0]   r_rgb;

    logic  w_pix_ce;
    logic  w_x_last;
    logic  w_y_last;
    logic  w_active;
    sync_t w_raw;
    sync_t w_tail;

    assign w_pix_ce = en && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_x_last = (r_x == CW'(H_TOTAL - 1));
    assign w_y_last = (r_y == CW'(V_TOTAL - 1));
    assign w_active = (r_x < CW'(H_ACTIVE)) && (r_y < CW'(V_ACTIVE));

    // Divider and raster counters; everything holds while en is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_frame_cnt <= '0;
        end else begin
            if (en) begin
                r_div <= w_pix_ce ? '0 : r_div + DIV_W'(1);
            end
            if (w_pix_ce) begin
                r_x <= w_x_last ? '0 : r_x + CW'(1);
                if (w_x_last) begin
                    r_y <= w_y_last ? '0 : r_y + CW'(1);
                    if (w_y_last) begin
                        r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
                    end
                end
            end
        end
    end

    // Undelayed sync windows and blank for the pixel currently on x/y.
    always_comb begin
        w_raw       = SYNC_RST;
        w_raw.hs    = (r_x >= CW'(HS_LO)) && (r_x <= CW'(HS_HI));
        w_raw.vs    = (r_y >= CW'(VS_LO)) && (r_y <= CW'(VS_HI));
        w_raw.blank = !w_active;
    end

    sync_delay_line #(
        .W       ($bits(sync_t)),
        .DEPTH   (PIPE_LAT),
        .RST_VAL (SYNC_RST)
    ) u_sync_delay (
        .clk     (clk),
        .reset   (reset),
        .i_shift (w_pix_ce),
        .i_d     (w_raw),
        .o_q     (w_tail)
    );

    // Output stage: polarity applied here, colour forced to zero while blanked.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync <= ~HS_POL;
            r_vsync <= ~VS_POL;
            r_blank <= 1'b1;
            r_rgb   <= '0;
        end else if (w_pix_ce) begin
            r_hsync <= w_tail.hs ? HS_POL : ~HS_POL;
            r_vsync <= w_tail.vs ? VS_POL : ~VS_POL;
            r_blank <= w_tail.blank;
            r_rgb   <= w_tail.blank ? '0 : rgb_in;
        end
    end

    assign pix_ce    = w_pix_ce;
    assign x         = r_x;
    assign y         = r_y;
    assign active    = w_active;
    assign sol       = w_pix_ce && (r_x == '0);
    assign sof       = w_pix_ce && (r_x == '0) && (r_y == '0);
    assign frame_cnt = r_frame_cnt;
    assign rgb_out   = r_rgb;
    assign blank_out = r_blank;
    assign hsync     = r_hsync;
    assign vsync     = r_vsync;

endmodule

// File: doc/video_timing_pipe.md
# video_timing_pipe

Parametrised successor to the fixed 640x480 VGA timing generator. Produces pixel coordinates, start-of-line/start-of-frame strobes and a frame counter for the raster and vertex stages. Delays sync and blank by a configurable number of pixel ticks so they line up with colour data returned from a pipelined pixel path. Emits the registered, blank-gated RGB and sync pair that drives the Tiny VGA PMOD.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- HS_POL / VS_POL, 0 / 0, active sync level (0 = active-low)
- CLK_DIV, 1, clocks per pixel tick (≥1)
- PIPE_LAT, 0, pixel-tick latency of the downstream colour path (0..15)
- RGB_W, 6, colour bus width
- CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- en  in  1  run enable; low freezes all state
- pix_ce  out  1  pixel tick strobe
- x  out  CW  horizontal counter (registered)
- y  out  CW  vertical counter (registered)
- active  out  1  x<H_ACTIVE && y<V_ACTIVE (comb. from counters)
- sol  out  1  pix_ce && x==0
- sof  out  1  pix_ce && x==0 && y==0
- frame_cnt  out  8  completed frames, wraps 255→0
- rgb_in  in  RGB_W  colour for the pixel shown on x/y PIPE_LAT ticks earlier
- rgb_out  out  RGB_W  registered colour, zero when blanked
- blank_out  out  1  registered, delayed !active
- hsync / vsync  out  1  registered, delayed syncs at HS_POL/VS_POL

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider `div` counts 0..CLK_DIV-1 while en. pix_ce = en && div==CLK_DIV-1. With CLK_DIV=1, pix_ce = en.
- On pix_ce: x increments and wraps H_TOTAL-1→0. At that wrap, y increments and wraps V_TOTAL-1→0.
- At the (H_TOTAL-1, V_TOTAL-1) wrap, frame_cnt increments.
- Raw hsync is active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]. Raw vsync is active for y in the equivalent window.
- Raw blank = !active.
- Delay line of PIPE_LAT stages carries {hs, vs, blank} and shifts only on pix_ce.
- Output register loads only on pix_ce:
  - hsync/vsync ← delay-line tail (raw values if PIPE_LAT=0)
  - blank_out ← delayed blank
  - rgb_out ← delayed blank ? 0 : rgb_in
- en low: div, counters, delay line and outputs hold. pix_ce/sol/sof are 0.

## Timing
- Reset values:
  - x=0, y=0, div=0, frame_cnt=0
  - hsync=!HS_POL, vsync=!VS_POL
  - blank_out=1, rgb_out=0
  - every delay stage = {inactive, inactive, blank=1}
- Reset mid-operation takes effect on the next edge regardless of en; no partial line is completed.
- Latency: outputs for pixel (x,y) appear on the clock after the pix_ce that occurs PIPE_LAT ticks after x/y showed that pixel, i.e. (PIPE_LAT+1)·CLK_DIV clocks after the counters.
- rgb_in is sampled only on pix_ce edges; between ticks it is don't-care.
- The first PIPE_LAT+1 ticks after reset output blanked, inactive syncs.
- Simultaneous reset and en: reset wins.

## Structure
- Package video_timing_pkg holds:
  - the default 640x480@60 timing constants
  - a localparam function computing H_TOTAL/V_TOTAL
  - an elaboration check that CW is sufficient and CLK_DIV≥1
- Sub-module sync_delay_line: a parametrised width/depth shift register with shift-enable and reset value. Depth 0 is a pass-through.

## Test plan
- Default params, CLK_DIV=1, PIPE_LAT=0: run 800 clocks after reset → hsync low for exactly 96 consecutive clocks, starting the clock after x=656. blank_out high for 160 clocks per line.
- Full frame of 420000 clocks → frame_cnt=1, one sof pulse, vsync low for exactly 1600 clocks, starting the clock after x=0,y=490.
- PIPE_LAT=2, rgb_in = x[5:0] delayed two ticks by the bench → rgb_out equals the registered x pattern only while blank_out=0, zero otherwise. hsync edges are 2 clocks later than with PIPE_LAT=0.
- CLK_DIV=2, H_ACTIVE=8 with H_FP/H_SYNC/H_BP=2/2/2, V set to 4/1/1/1 → pix_ce every other clock, line = 28 clocks, frame = 196 clocks.
- en dropped at x=300 for 50 clocks → x, y, hsync, rgb_out frozen, no pix_ce. Resume continues at x=301.
- reset asserted at x=400, y=200 → next clock x=0, y=0, frame_cnt=0, rgb_out=0, blank_out=1, syncs inactive.
